// File: rtl/move_scheduler.sv
// move_scheduler: buffers fully assembled coordinated-move segments in a
// power-of-two ring and hands them to the DDA stepper executor one at a time.
// The next segment is offered only after the executor's completion pulse.
// Optional feature macro: MOVE_HALT_EN adds the halt_n port and the
// flush/abort path. Without it, seg_abort is tied low and the buffer drains
// only through normal dispatch.
module move_scheduler #(
    parameter int BUFFER_BITS = 2,
    parameter int SEG_W       = 64
) (
    input  logic                   CLK,
    input  logic                   resetn,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic                   wr_dir,
    input  logic [SEG_W-1:0]       wr_duration,
    input  logic [SEG_W-1:0]       wr_increment,
    input  logic [SEG_W-1:0]       wr_incinc,
    output logic                   seg_valid,
    input  logic                   seg_ready,
    output logic                   seg_dir,
    output logic [SEG_W-1:0]       seg_duration,
    output logic [SEG_W-1:0]       seg_increment,
    output logic [SEG_W-1:0]       seg_incinc,
    input  logic                   seg_done,
    output logic                   seg_abort,
`ifdef MOVE_HALT_EN
    input  logic                   halt_n,
`endif
    output logic                   buffer_dtr,
    output logic                   move_done,
    output logic [BUFFER_BITS:0]   level,
    output logic                   overflow
);

    localparam int DEPTH = 1 << BUFFER_BITS;
    localparam logic [BUFFER_BITS-1:0] PTR_ONE = BUFFER_BITS'(1);
    localparam logic [BUFFER_BITS:0]   LVL_ONE = (BUFFER_BITS + 1)'(1);
    localparam logic [BUFFER_BITS:0]   LVL_FULL = (BUFFER_BITS + 1)'(DEPTH);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                 state_r;
    logic [BUFFER_BITS-1:0] wr_ptr_r;
    logic [BUFFER_BITS-1:0] rd_ptr_r;
    logic [BUFFER_BITS:0]   level_r;
    logic                   move_done_r;
    logic                   overflow_r;

    logic                   dir_mem_r    [DEPTH];
    logic [SEG_W-1:0]       dur_mem_r    [DEPTH];
    logic [SEG_W-1:0]       inc_mem_r    [DEPTH];
    logic [SEG_W-1:0]       incinc_mem_r [DEPTH];

    logic halt_s;
    logic full_s;
    logic empty_s;
    logic wr_fire_s;
    logic dispatch_s;

`ifdef MOVE_HALT_EN
    logic seg_abort_r;

    assign halt_s = ~halt_n;

    // Abort pulse: one cycle after a halt is sampled while a segment is executing.
    always_ff @(posedge CLK) begin
        if (!resetn) begin
            seg_abort_r <= 1'b0;
        end else begin
            seg_abort_r <= halt_s & (state_r == ST_RUN);
        end
    end

    assign seg_abort = seg_abort_r;
`else
    assign halt_s    = 1'b0;
    assign seg_abort = 1'b0;
`endif

    assign full_s     = (level_r == LVL_FULL);
    assign empty_s    = (level_r == '0);
    // While halting the host may keep pushing; those writes are silently discarded.
    assign wr_ready   = ~full_s | halt_s;
    assign buffer_dtr = ~full_s | halt_s;
    assign wr_fire_s  = wr_valid & ~full_s & ~halt_s;
    assign seg_valid  = (state_r == ST_IDLE) & ~empty_s & ~halt_s;
    assign dispatch_s = seg_valid & seg_ready;

    assign seg_dir       = dir_mem_r[rd_ptr_r];
    assign seg_duration  = dur_mem_r[rd_ptr_r];
    assign seg_increment = inc_mem_r[rd_ptr_r];
    assign seg_incinc    = incinc_mem_r[rd_ptr_r];

    assign level     = level_r;
    assign move_done = move_done_r;
    assign overflow  = overflow_r;

    // Segment storage: capture an accepted write at the write pointer.
    always_ff @(posedge CLK) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                dir_mem_r[i]    <= 1'b0;
                dur_mem_r[i]    <= '0;
                inc_mem_r[i]    <= '0;
                incinc_mem_r[i] <= '0;
            end
        end else if (wr_fire_s) begin
            dir_mem_r[wr_ptr_r]    <= wr_dir;
            dur_mem_r[wr_ptr_r]    <= wr_duration;
            inc_mem_r[wr_ptr_r]    <= wr_increment;
            incinc_mem_r[wr_ptr_r] <= wr_incinc;
        end
    end

    // Dispatch FSM plus pointer, occupancy, done-toggle and overflow bookkeeping.
    always_ff @(posedge CLK) begin
        if (!resetn) begin
            state_r     <= ST_IDLE;
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            level_r     <= '0;
            move_done_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else if (halt_s) begin
            // Flush: drop everything queued, forget the running segment.
            rd_ptr_r <= wr_ptr_r;
            level_r  <= '0;
            state_r  <= ST_IDLE;
        end else begin
            if (wr_fire_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (wr_valid && full_s) begin
                overflow_r <= 1'b1;
            end
            if (dispatch_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({wr_fire_s, dispatch_s})
                2'b10:   level_r <= level_r + LVL_ONE;
                2'b01:   level_r <= level_r - LVL_ONE;
                default: level_r <= level_r;
            endcase
            case (state_r)
                ST_IDLE: begin
                    if (dispatch_s) begin
                        state_r <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (seg_done) begin
                        move_done_r <= ~move_done_r;
                        state_r     <= ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

endmodule
